layer0_feature_packer: RTL

Front-end stage that feeds the layer-0 LUT neurons. It accepts quantized input features one per beat over a valid/ready stream and assembles them into the full flat input vector that the layer-0 neurons slice their 6-bit fan-in from. It then presents each completed vector on a registered valid/ready output. Double buffering (collect register plus output register) sustains one vector per NUM_FEATURES cycles with no bubbles.

---
 rtl/layer0_feature_packer.sv | 105 ++++++++++
 1 files changed

// File: rtl/layer0_feature_packer.sv
// Collects quantized features one per beat and presents each completed flat
// vector to the layer-0 neurons on a registered valid/ready output.
module layer0_feature_packer #(
  parameter int NUM_FEATURES = 32,
  parameter int FEAT_BW      = 2,
  localparam int VEC_BW      = NUM_FEATURES * FEAT_BW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_BW-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VEC_BW-1:0] m_data,
  output logic              frame_err,
  output logic [15:0]       vec_count,
  output logic [7:0]        err_count
);

  // state   | meaning
  // COLLECT | accepting beats into the collect register
  // HOLD    | complete vector parked, waiting for the output slot to free
  typedef enum logic {COLLECT, HOLD} state_t;

  localparam int IW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEATURES - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic [VEC_BW-1:0] coll;
  logic [VEC_BW-1:0] final_vec;
  logic              at_end;
  logic              beat;
  logic              bad_frame;
  logic              slot_free;
  logic              consume;

  assign s_ready   = (state == COLLECT);
  assign beat      = s_valid && (state == COLLECT);
  assign at_end    = (idx == LAST_IDX);
  assign bad_frame = s_last ^ at_end;
  assign consume   = m_valid && m_ready;
  assign slot_free = !m_valid || m_ready;

  // Final beat merged into the collect register so it can bypass straight out.
  always_comb begin
    final_vec = coll;
    final_vec[(NUM_FEATURES-1)*FEAT_BW +: FEAT_BW] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      coll      <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      if (consume) begin
        m_valid   <= 1'b0;
        vec_count <= vec_count + 16'd1;
      end

      case (state)
        COLLECT: begin
          if (beat) begin
            if (bad_frame) begin
              idx       <= '0;
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (at_end) begin
              if (slot_free) begin
                m_data  <= final_vec;
                m_valid <= 1'b1;
                idx     <= '0;
              end else begin
                coll  <= final_vec;
                state <= HOLD;
              end
            end else begin
              coll[idx*FEAT_BW +: FEAT_BW] <= s_data;
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            m_data  <= coll;
            m_valid <= 1'b1;
            idx     <= '0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
